// File: rtl/venera_core_p_if.sv
// venera_core_p_if: instruction and data memory handshake bundle for the venera core
interface venera_core_p_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              instr_req;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_ack;
    logic [ADDR_W+3:0] instr_data;
    logic              data_rd;
    logic              data_wr;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_ack;
    logic [DATA_W-1:0] data_rdata;
    modport master (
        output instr_req, instr_addr, data_rd, data_wr, data_addr, data_wdata,
        input  instr_ack, instr_data, data_ack, data_rdata
    );
    modport slave (
        input  instr_req, instr_addr, data_rd, data_wr, data_addr, data_wdata,
        output instr_ack, instr_data, data_ack, data_rdata
    );
endinterface

// File: rtl/venera_core_p.sv
// venera_core_p: multi-cycle accumulator core with Z/C flags and stalling ready/ack memories
module venera_core_p #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               areset,
    venera_core_p_if.master    bus,
    output logic [DATA_W-1:0]  acc,
    output logic               flag_z,
    output logic               flag_c,
    output logic               halted
);
    typedef enum logic [2:0] {START, FETCH, EXEC, MEM, HALT} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              z_q, z_d, c_q, c_d;
    logic [ADDR_W+3:0] ir_q, ir_d;
    logic              instr_req_q, instr_req_d;
    logic              data_rd_q, data_rd_d;
    logic              data_wr_q, data_wr_d;
    logic              halted_q, halted_d;
    logic [3:0]        op;
    logic [ADDR_W-1:0] opnd;
    logic [DATA_W-1:0] src, res;
    logic [DATA_W:0]   sum, diff;
    logic              res_c, writes_acc, is_mem, taken, done;

    assign op         = ir_q[ADDR_W+3:ADDR_W];
    assign opnd       = ir_q[ADDR_W-1:0];
    assign src        = (state_q == MEM) ? bus.data_rdata : DATA_W'(opnd);
    assign sum        = {1'b0, acc_q} + {1'b0, src};
    assign diff       = {1'b0, acc_q} - {1'b0, src};
    assign is_mem     = (op >= 4'h1) && (op <= 4'h7);
    assign writes_acc = (is_mem && op != 4'h2) || op == 4'h8 || op == 4'hC || op == 4'hD;
    assign taken      = op == 4'h9 || (op == 4'hA && z_q) || (op == 4'hB && c_q);
    assign done       = (state_q == EXEC && !is_mem && op != 4'hF) || (state_q == MEM && bus.data_ack);

    assign bus.instr_req  = instr_req_q;
    assign bus.instr_addr = instr_req_q ? pc_q : '0;
    assign bus.data_rd    = data_rd_q;
    assign bus.data_wr    = data_wr_q;
    assign bus.data_addr  = (data_rd_q || data_wr_q) ? opnd : '0;
    assign bus.data_wdata = acc_q;
    assign acc            = acc_q;
    assign flag_z         = z_q;
    assign flag_c         = c_q;
    assign halted         = halted_q;

    // ALU: new accumulator value and carry for the current opcode (borrow lands in diff's top bit)
    always_comb begin
        res   = acc_q;
        res_c = 1'b0;
        case (op)
            4'h1, 4'h8: res = src;
            4'h3:       {res_c, res} = sum;
            4'h4:       {res_c, res} = diff;
            4'h5:       res = acc_q & src;
            4'h6:       res = acc_q | src;
            4'h7:       res = acc_q ^ src;
            4'hC:       {res_c, res} = {acc_q, 1'b0};
            4'hD:       {res, res_c} = {1'b0, acc_q};
            default:    ;
        endcase
    end

    // Sequencer: fetch/exec/mem stepping, requests held until acked, retirement updates PC and flags
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        acc_d       = acc_q;
        z_d         = z_q;
        c_d         = c_q;
        ir_d        = ir_q;
        instr_req_d = 1'b0;
        data_rd_d   = 1'b0;
        data_wr_d   = 1'b0;
        halted_d    = halted_q;
        case (state_q)
            START: begin
                state_d     = FETCH;
                instr_req_d = 1'b1;
            end
            FETCH: begin
                if (bus.instr_ack) begin
                    ir_d    = bus.instr_data;
                    state_d = EXEC;
                end else
                    instr_req_d = 1'b1;
            end
            EXEC: begin
                if (is_mem) begin
                    state_d   = MEM;
                    data_rd_d = op != 4'h2;
                    data_wr_d = op == 4'h2;
                end else if (op == 4'hF) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end
            end
            MEM: begin
                if (!bus.data_ack) begin
                    data_rd_d = data_rd_q;
                    data_wr_d = data_wr_q;
                end
            end
            default: ;
        endcase
        if (done) begin
            state_d     = FETCH;
            instr_req_d = 1'b1;
            pc_d        = taken ? opnd : pc_q + ADDR_W'(1);
            if (writes_acc) begin
                acc_d = res;
                c_d   = res_c;
                z_d   = res == '0;
            end
        end
    end

    // State and registered outputs; reset drops any outstanding request immediately
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= START;
            pc_q        <= ADDR_W'(RESET_PC);
            acc_q       <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            ir_q        <= '0;
            instr_req_q <= 1'b0;
            data_rd_q   <= 1'b0;
            data_wr_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            acc_q       <= acc_d;
            z_q         <= z_d;
            c_q         <= c_d;
            ir_q        <= ir_d;
            instr_req_q <= instr_req_d;
            data_rd_q   <= data_rd_d;
            data_wr_q   <= data_wr_d;
            halted_q    <= halted_d;
        end
    end
endmodule
